instr_block_mem: RTL and testbench

INSTR_BLOCK_MEM -- requirements
Module: instr_block_mem

---
 rtl/imem_pkg.sv | 23 ++
 rtl/imem_byte_array.sv | 36 +++
 rtl/instr_block_mem.sv | 163 ++++++++++++++++
 tb/tb_instr_block_mem.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction block memory.
// Holds the FSM state encoding, width helpers and parameter range limits.
package imem_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2,
    S_DONE  = 2'd3
  } imem_state_e;

  localparam int unsigned FETCH_ADDR_W   = 32;
  localparam int unsigned LINE_BYTES_MIN = 4;
  localparam int unsigned LINE_BYTES_MAX = 64;
  localparam int unsigned LATENCY_MAX    = 15;
  localparam int unsigned WAIT_W         = $clog2(LATENCY_MAX + 1);

  // Counter width that never collapses to zero bits.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/imem_byte_array.sv
// Byte-addressed program storage: one byte-wide write port and one
// BEAT_BYTES-wide asynchronous read port.
module imem_byte_array
  import imem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int BEAT_BYTES  = 1
) (
  input  logic                           clock,
  input  logic                           wr_en,
  input  logic [$clog2(DEPTH_BYTES)-1:0] wr_addr,
  input  logic [7:0]                     wr_data,
  input  logic [$clog2(DEPTH_BYTES)-1:0] rd_addr,
  output logic [8*BEAT_BYTES-1:0]        rd_data
);

  localparam int ADDR_W = $clog2(DEPTH_BYTES);

  logic [7:0] mem_r [DEPTH_BYTES];

  // Preload write; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Beat read; a same-edge write is seen only after the edge.
  always_comb begin
    rd_data = {(8*BEAT_BYTES){1'b0}};
    for (int i = 0; i < BEAT_BYTES; i++) begin
      rd_data[i*8 +: 8] = mem_r[rd_addr + ADDR_W'(i)];
    end
  end

endmodule

// File: rtl/instr_block_mem.sv
// Instruction memory returning whole lines to the cache in beat bursts.
// Optional IMEM_RANGE_CHECK_EN adds the err port for out-of-range fetches.
module instr_block_mem
  import imem_pkg::*;
#(
  parameter int LINE_BYTES  = 16,
  parameter int BEAT_BYTES  = 1,
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 0
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 read,
  input  logic [FETCH_ADDR_W-$clog2(LINE_BYTES)-1:0] address,
  input  logic                                 ld_en,
  input  logic [$clog2(DEPTH_BYTES)-1:0]       ld_addr,
  input  logic [7:0]                           ld_data,
  output logic [8*LINE_BYTES-1:0]              readdata,
  output logic                                 busywait
`ifdef IMEM_RANGE_CHECK_EN
  ,
  output logic                                 err
`endif
);

  localparam int OFF_W     = $clog2(LINE_BYTES);
  localparam int ADDR_W    = $clog2(DEPTH_BYTES);
  localparam int LINE_W    = FETCH_ADDR_W - OFF_W;
  localparam int NBEATS    = LINE_BYTES / BEAT_BYTES;
  localparam int BEAT_W    = width_of(NBEATS);
  localparam int BEAT_SH   = $clog2(BEAT_BYTES);
  localparam int BEAT_BITS = 8 * BEAT_BYTES;

  imem_state_e              state_r, next_state_s;
  logic [LINE_W-1:0]        line_r;
  logic [BEAT_W-1:0]        beat_r;
  logic [WAIT_W-1:0]        wait_r;
  logic [8*LINE_BYTES-1:0]  readdata_r;
  logic                     accept_s, wait_inc_s, beat_wr_s, beat_inc_s, done_set_s;
  logic [OFF_W-1:0]         beat_off_s;
  logic [ADDR_W-1:0]        rd_addr_s;
  logic [BEAT_BITS-1:0]     rd_data_s, beat_data_s;

  // Truncating to ADDR_W bits gives the modulo-depth wrap.
  assign beat_off_s = OFF_W'(beat_r) << BEAT_SH;
  assign rd_addr_s  = ADDR_W'({line_r, beat_off_s});

  imem_byte_array #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .BEAT_BYTES  (BEAT_BYTES)
  ) u_array (
    .clock   (clock),
    .wr_en   (ld_en),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s)
  );

`ifdef IMEM_RANGE_CHECK_EN
  logic oor_s;
  logic err_r;
  assign oor_s       = |(line_r >> (ADDR_W - OFF_W));
  assign beat_data_s = oor_s ? {BEAT_BITS{1'b0}} : rd_data_s;
  assign err         = err_r;

  // Error flag: set as the out-of-range line completes, cleared on acceptance.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_r <= 1'b0;
    end else if (accept_s) begin
      err_r <= 1'b0;
    end else if (done_set_s && oor_s) begin
      err_r <= 1'b1;
    end
  end
`else
  assign beat_data_s = rd_data_s;
`endif

  assign busywait = read && (state_r != S_DONE);
  assign readdata = readdata_r;

  // Next-state and datapath control decode.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    wait_inc_s   = 1'b0;
    beat_wr_s    = 1'b0;
    beat_inc_s   = 1'b0;
    done_set_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (read) begin
          accept_s     = 1'b1;
          next_state_s = (LATENCY > 0) ? S_WAIT : S_BURST;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!read) begin
          next_state_s = S_IDLE;
        end else if (wait_r == WAIT_W'(LATENCY - 1)) begin
          next_state_s = S_BURST;
        end else begin
          wait_inc_s   = 1'b1;
          next_state_s = S_WAIT;
        end
      end
      S_BURST: begin
        if (!read) begin
          next_state_s = S_IDLE;
        end else begin
          beat_wr_s = 1'b1;
          if (beat_r == BEAT_W'(NBEATS - 1)) begin
            done_set_s   = 1'b1;
            next_state_s = S_DONE;
          end else begin
            beat_inc_s   = 1'b1;
            next_state_s = S_BURST;
          end
        end
      end
      S_DONE:  next_state_s = S_IDLE;
      default: next_state_s = S_IDLE;
    endcase
  end

  // State, latched line address and beat/wait counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
      line_r  <= {LINE_W{1'b0}};
      beat_r  <= {BEAT_W{1'b0}};
      wait_r  <= {WAIT_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      if (accept_s) begin
        line_r <= address;
        beat_r <= {BEAT_W{1'b0}};
        wait_r <= {WAIT_W{1'b0}};
      end else begin
        if (wait_inc_s) wait_r <= wait_r + WAIT_W'(1);
        if (beat_inc_s) beat_r <= beat_r + BEAT_W'(1);
      end
    end
  end

  // Line buffer: only the current beat's lane changes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      readdata_r <= {(8*LINE_BYTES){1'b0}};
    end else if (beat_wr_s) begin
      for (int i = 0; i < NBEATS; i++) begin
        if (beat_r == BEAT_W'(i)) begin
          readdata_r[i*BEAT_BITS +: BEAT_BITS] <= beat_data_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_block_mem.sv
// Directed bench for instr_block_mem: a default instance and a
// BEAT_BYTES=4 / LATENCY=3 instance sharing reset and preload.
module tb_instr_block_mem;

  logic         clock = 1'b0;
  logic         reset;
  logic         read0, read1;
  logic [27:0]  addr0, addr1;
  logic         ld_en;
  logic [9:0]   ld_addr;
  logic [7:0]   ld_data;
  logic [127:0] rd0, rd1;
  logic         busy0, busy1;
`ifdef IMEM_RANGE_CHECK_EN
  logic         err0, err1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  instr_block_mem dut0 (
    .clock(clock), .reset(reset), .read(read0), .address(addr0),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .readdata(rd0), .busywait(busy0)
`ifdef IMEM_RANGE_CHECK_EN
    , .err(err0)
`endif
  );

  instr_block_mem #(.BEAT_BYTES(4), .LATENCY(3)) dut1 (
    .clock(clock), .reset(reset), .read(read1), .address(addr1),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .readdata(rd1), .busywait(busy1)
`ifdef IMEM_RANGE_CHECK_EN
    , .err(err1)
`endif
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load_byte(input int a, input logic [7:0] d);
    ld_en   = 1'b1;
    ld_addr = 10'(a);
    ld_data = d;
    step();
    ld_en   = 1'b0;
  endtask

  // Raise read on dut0 and count edges until busywait drops (bounded).
  task automatic fetch0(input logic [27:0] a, output int edges);
    addr0 = a;
    read0 = 1'b1;
    edges = 0;
    do begin
      step();
      edges++;
    end while (busy0 && edges < 64);
  endtask

  task automatic finish0();
    read0 = 1'b0;
    step();
  endtask

  task automatic test_reset();
    int e;
    reset = 1'b0; read0 = 1'b1; read1 = 1'b0;
    step(); step();
    n_checks++;
    if (rd0 !== 128'h0) begin n_fail++; $display("FAIL reset_readdata got %h expected 0", rd0); end
    n_checks++;
    if (busy0 !== 1'b1) begin n_fail++; $display("FAIL reset_busy_read1 got %b expected 1", busy0); end
    n_checks++;
    if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy_read0 got %b expected 0", busy1); end
`ifdef IMEM_RANGE_CHECK_EN
    n_checks++;
    if (err0 !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b expected 0", err0); end
`endif
    read0 = 1'b0;
    reset = 1'b1;
    step();
    for (int i = 0; i < 128; i++) load_byte(i, 8'(i));
    e = 0;
  endtask

  task automatic test_default_fetch();
    int e;
    fetch0(28'd0, e);
    n_checks++;
    if (e != 17) begin n_fail++; $display("FAIL default_latency got %0d expected 17", e); end
    n_checks++;
    if (rd0 !== 128'h0F0E0D0C0B0A09080706050403020100) begin
      n_fail++; $display("FAIL default_data got %h expected 0f0e..0100", rd0);
    end
    finish0();
    n_checks++;
    if (busy0 !== 1'b0 || rd0 !== 128'h0F0E0D0C0B0A09080706050403020100) begin
      n_fail++; $display("FAIL default_hold got busy=%b data=%h expected busy=0 line 0", busy0, rd0);
    end
  endtask

  task automatic test_beat4();
    int e;
    addr1 = 28'd1;
    read1 = 1'b1;
    e = 0;
    do begin
      step();
      e++;
    end while (busy1 && e < 64);
    n_checks++;
    if (e != 8) begin n_fail++; $display("FAIL beat4_latency got %0d expected 8", e); end
    n_checks++;
    if (rd1 !== 128'h1F1E1D1C1B1A19181716151413121110) begin
      n_fail++; $display("FAIL beat4_data got %h expected 1f1e..1110", rd1);
    end
    read1 = 1'b0;
    step();
  endtask

  task automatic test_abort();
    int e;
    addr0 = 28'd5;
    read0 = 1'b1;
    for (int i = 0; i < 6; i++) step();
    read0 = 1'b0;
    step(); step(); step();
    n_checks++;
    if (rd0 !== 128'h0F0E0D0C0B0A09080706055453525150) begin
      n_fail++; $display("FAIL abort_partial got %h expected 0f0e..0554535251 50", rd0);
    end
    fetch0(28'd2, e);
    n_checks++;
    if (e != 17) begin n_fail++; $display("FAIL abort_refetch_latency got %0d expected 17", e); end
    n_checks++;
    if (rd0 !== 128'h2F2E2D2C2B2A29282726252423222120) begin
      n_fail++; $display("FAIL abort_refetch_data got %h expected 2f2e..2120", rd0);
    end
    finish0();
  endtask

  task automatic test_reset_mid();
    int e;
    addr0 = 28'd3;
    read0 = 1'b1;
    for (int i = 0; i < 8; i++) step();
    reset = 1'b0;
    #1;
    n_checks++;
    if (rd0 !== 128'h0 || busy0 !== 1'b1) begin
      n_fail++; $display("FAIL midreset_clear got data=%h busy=%b expected 0 and 1", rd0, busy0);
    end
    read0 = 1'b0;
    step();
    reset = 1'b1;
    step();
    fetch0(28'd0, e);
    n_checks++;
    if (e != 17 || rd0 !== 128'h0F0E0D0C0B0A09080706050403020100) begin
      n_fail++; $display("FAIL midreset_refetch got edges=%0d data=%h expected 17 line 0", e, rd0);
    end
    finish0();
  endtask

  task automatic test_load_collision();
    int e;
    addr0 = 28'd0;
    read0 = 1'b1;
    for (int i = 0; i < 4; i++) step();
    ld_en = 1'b1; ld_addr = 10'd3; ld_data = 8'hAB;
    step();
    ld_en = 1'b0;
    e = 5;
    do begin
      step();
      e++;
    end while (busy0 && e < 64);
    n_checks++;
    if (e != 17 || rd0 !== 128'h0F0E0D0C0B0A09080706050403020100) begin
      n_fail++; $display("FAIL collision_old got edges=%0d data=%h expected 17 line 0 old byte", e, rd0);
    end
    finish0();
    fetch0(28'd0, e);
    n_checks++;
    if (rd0 !== 128'h0F0E0D0C0B0A090807060504AB020100) begin
      n_fail++; $display("FAIL collision_new got %h expected byte3=ab", rd0);
    end
    finish0();
  endtask

  task automatic test_back_to_back();
    int e;
    fetch0(28'd1, e);
    n_checks++;
    if (rd0 !== 128'h1F1E1D1C1B1A19181716151413121110) begin
      n_fail++; $display("FAIL b2b_first got %h expected 1f1e..1110", rd0);
    end
    addr0 = 28'd4;
    e = 0;
    do begin
      step();
      e++;
      if (e == 5) addr0 = 28'd7;
    end while (busy0 && e < 64);
    n_checks++;
    if (e != 18) begin n_fail++; $display("FAIL b2b_latency got %0d expected 18", e); end
    n_checks++;
    if (rd0 !== 128'h4F4E4D4C4B4A49484746454443424140) begin
      n_fail++; $display("FAIL b2b_data got %h expected 4f4e..4140", rd0);
    end
    finish0();
  endtask

  task automatic test_range();
    int e;
    fetch0(28'd64, e);
    n_checks++;
    if (e != 17) begin n_fail++; $display("FAIL range_latency got %0d expected 17", e); end
`ifdef IMEM_RANGE_CHECK_EN
    n_checks++;
    if (err0 !== 1'b1 || rd0 !== 128'h0) begin
      n_fail++; $display("FAIL range_err got err=%b data=%h expected 1 and 0", err0, rd0);
    end
    finish0();
    addr0 = 28'd0;
    read0 = 1'b1;
    step();
    n_checks++;
    if (err0 !== 1'b0) begin n_fail++; $display("FAIL range_err_clear got %b expected 0", err0); end
    e = 1;
    do begin
      step();
      e++;
    end while (busy0 && e < 64);
`else
    n_checks++;
    if (rd0 !== 128'h0F0E0D0C0B0A090807060504AB020100) begin
      n_fail++; $display("FAIL range_wrap got %h expected line 0", rd0);
    end
`endif
    finish0();
  endtask

  initial begin
    reset = 1'b0; read0 = 1'b0; read1 = 1'b0;
    addr0 = 28'd0; addr1 = 28'd0;
    ld_en = 1'b0; ld_addr = 10'd0; ld_data = 8'd0;
    test_reset();
    test_default_fetch();
    test_beat4();
    test_abort();
    test_reset_mid();
    test_load_collision();
    test_back_to_back();
    test_range();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
